// File: rtl/nios_system_onchip_mem_arbiter_pkg.sv
// Shared types and default sizing for the two-master on-chip memory arbiter.
// Master index and the read-response pipeline record live here so the top and the arbiter agree.
package nios_system_onchip_mem_arbiter_pkg;

   localparam int DEF_ADDR_W   = 17;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUMWORDS = 100000;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_t;

   // One in-flight read: who issued it and whether it fell outside the memory.
   typedef struct packed {
      logic    valid;
      master_t owner;
      logic    oor;
   } rsp_t;

endpackage

// File: rtl/nios_system_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master not granted last.
module nios_system_rr_arb2
   import nios_system_onchip_mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  master_t    last_grant,
   output logic       gnt_valid,
   output master_t    gnt
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      gnt = M0;
      case (req)
         2'b10:   gnt = M1;
         2'b11:   gnt = (last_grant == M0) ? M1 : M0;
         default: gnt = M0;
      endcase
   end

   assign gnt_valid = |req;

endmodule

// File: rtl/nios_system_onchip_mem_arbiter.sv
// Shares one single-port on-chip memory between two Avalon-style masters with round-robin
// arbitration, out-of-range detection and a one-cycle read-response pipeline.
module nios_system_onchip_mem_arbiter
   import nios_system_onchip_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUMWORDS = DEF_NUMWORDS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   output logic                m0_oor_err,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic                m1_oor_err,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int          BE_W  = DATA_W / 8;
   localparam logic [31:0] LIMIT = NUMWORDS;

   logic [1:0]        req;
   logic              gnt_valid;
   logic              active;
   master_t           gnt;
   master_t           last_grant;
   logic [ADDR_W-1:0] sel_address;
   logic [BE_W-1:0]   sel_byteenable;
   logic [DATA_W-1:0] sel_writedata;
   logic              sel_read;
   logic              sel_write;
   logic              sel_oor;
   logic [ADDR_W-1:0] address_q;
   logic [BE_W-1:0]   byteenable_q;
   logic [DATA_W-1:0] writedata_q;
   rsp_t              rsp_q;
   logic [1:0]        oor_q;
   logic [DATA_W-1:0] rsp_data;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   nios_system_rr_arb2 u_arb (
      .req        (req),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt        (gnt)
   );

   // Everything the block drives is forced quiet while reset is held.
   assign active = reset_n & gnt_valid;

   always_comb begin
      sel_address    = m0_address;
      sel_byteenable = m0_byteenable;
      sel_writedata  = m0_writedata;
      sel_read       = m0_read;
      sel_write      = m0_write;
      if (gnt == M1) begin
         sel_address    = m1_address;
         sel_byteenable = m1_byteenable;
         sel_writedata  = m1_writedata;
         sel_read       = m1_read;
         sel_write      = m1_write;
      end
   end

   assign sel_oor = 32'(sel_address) >= LIMIT;

   assign m0_waitrequest = reset_n & req[0] & (gnt != M0);
   assign m1_waitrequest = reset_n & req[1] & (gnt != M1);

   // Idle cycles replay the last granted address/data rather than toggling the memory bus.
   assign mem_address    = active ? sel_address    : address_q;
   assign mem_byteenable = active ? sel_byteenable : byteenable_q;
   assign mem_writedata  = active ? sel_writedata  : writedata_q;
   assign mem_chipselect = active & ~sel_oor;
   assign mem_write      = active & sel_write & ~sel_oor;
   assign mem_clken      = reset_n;

   assign rsp_data         = rsp_q.oor ? '0 : mem_readdata;
   assign m0_readdatavalid = rsp_q.valid & (rsp_q.owner == M0);
   assign m1_readdatavalid = rsp_q.valid & (rsp_q.owner == M1);
   assign m0_readdata      = m0_readdatavalid ? rsp_data : rdata0_q;
   assign m1_readdata      = m1_readdatavalid ? rsp_data : rdata1_q;
   assign m0_oor_err       = oor_q[0];
   assign m1_oor_err       = oor_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant   <= M1;
         address_q    <= '0;
         byteenable_q <= '0;
         writedata_q  <= '0;
         rsp_q        <= '0;
         oor_q        <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         if (active) begin
            last_grant   <= gnt;
            address_q    <= sel_address;
            byteenable_q <= sel_byteenable;
            writedata_q  <= sel_writedata;
            if (sel_oor) oor_q[gnt] <= 1'b1;
         end
         // A simultaneous read and write is treated as the write alone.
         rsp_q <= '{valid: active & sel_read & ~sel_write, owner: gnt, oor: sel_oor};
         if (m0_readdatavalid) rdata0_q <= rsp_data;
         if (m1_readdatavalid) rdata1_q <= rsp_data;
      end
   end

endmodule

// File: tb/tb_nios_system_onchip_mem_arbiter.sv
// Randomised and directed bench for the on-chip memory arbiter, with a behavioural memory
// and a transaction-level reference model of grant, response and error behaviour.
module tb_nios_system_onchip_mem_arbiter;
   import nios_system_onchip_mem_arbiter_pkg::*;

   localparam int AW = 17;
   localparam int DW = 32;
   localparam int NW = 100000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] m0_address = '0, m1_address = '0;
   logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
   logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
   logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic          m0_oor_err, m1_oor_err;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata = '0;

   always #5 clk = ~clk;

   nios_system_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUMWORDS(NW)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_oor_err(m0_oor_err),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_oor_err(m1_oor_err),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // Behavioural synchronous RAM with one-cycle registered read.
   bit [31:0] ram [int];
   always @(posedge clk) begin
      int a;
      bit [31:0] w;
      a = int'(mem_address);
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            w = ram.exists(a) ? ram[a] : '0;
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
            ram[a] = w;
         end else begin
            mem_readdata <= ram.exists(a) ? ram[a] : '0;
         end
      end
   end

   typedef struct {
      bit        rd;
      bit        wr;
      int        addr;
      bit [3:0]  be;
      bit [31:0] wd;
   } mreq_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   bit [31:0] shadow [int];
   int        prev_winner = 1;
   bit        oor_flag [2];
   bit [31:0] last_rd [2];
   int        last_addr = 0;
   bit        pend_valid = 1'b0;
   int        pend_owner = 0;
   bit [31:0] pend_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic mreq_t mk(input bit rd, input bit wr, input int addr,
                                input bit [3:0] be = 4'hF, input bit [31:0] wd = '0);
      mreq_t r;
      r.rd = rd; r.wr = wr; r.addr = addr; r.be = be; r.wd = wd;
      return r;
   endfunction

   function automatic mreq_t rnd_req();
      int k;
      int addr;
      k = int'($urandom_range(0, 9));
      addr = ($urandom_range(0, 19) == 0) ? int'($urandom_range(NW - 2, 131071))
                                          : int'($urandom_range(0, 15));
      return mk(k < 4 || k == 9, (k >= 4 && k < 7) || k == 9, addr,
                4'($urandom_range(0, 15)), $urandom);
   endfunction

   function automatic bit [31:0] shadow_rd(input int a);
      return shadow.exists(a) ? shadow[a] : '0;
   endfunction

   task automatic drive(input mreq_t a, input mreq_t b);
      m0_read = a.rd; m0_write = a.wr; m0_address = AW'(a.addr);
      m0_byteenable = a.be; m0_writedata = a.wd;
      m1_read = b.rd; m1_write = b.wr; m1_address = AW'(b.addr);
      m1_byteenable = b.be; m1_writedata = b.wd;
   endtask

   // Called just after a rising edge; applies one cycle of requests and checks it.
   task automatic run_cycle(input mreq_t a, input mreq_t b);
      mreq_t q [2];
      bit    r [2];
      int    win;
      bit    oor, exp_v;
      bit [31:0] exp_d, w;
      q[0] = a; q[1] = b;
      #1 drive(a, b);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         exp_v = pend_valid && pend_owner == m;
         exp_d = exp_v ? pend_data : last_rd[m];
         check($sformatf("m%0d_readdatavalid", m), m == 0 ? m0_readdatavalid : m1_readdatavalid, exp_v);
         check($sformatf("m%0d_readdata", m), m == 0 ? m0_readdata : m1_readdata, exp_d);
         check($sformatf("m%0d_oor_err", m), m == 0 ? m0_oor_err : m1_oor_err, oor_flag[m]);
         last_rd[m] = exp_d;
         r[m] = q[m].rd | q[m].wr;
      end
      win = -1;
      if (r[0] && r[1]) win = 1 - prev_winner;
      else if (r[0])    win = 0;
      else if (r[1])    win = 1;
      check("m0_waitrequest", m0_waitrequest, r[0] && win != 0);
      check("m1_waitrequest", m1_waitrequest, r[1] && win != 1);
      oor = 1'b0;
      if (win >= 0) begin
         oor = q[win].addr >= NW;
         check("mem_chipselect", mem_chipselect, !oor);
         check("mem_write", mem_write, q[win].wr && !oor);
         check("mem_address", mem_address, q[win].addr);
         if (q[win].wr) begin
            check("mem_writedata", mem_writedata, q[win].wd);
            check("mem_byteenable", mem_byteenable, q[win].be);
         end
      end else begin
         check("idle_chipselect", mem_chipselect, 0);
         check("idle_write", mem_write, 0);
         check("idle_address_hold", mem_address, last_addr);
      end
      check("mem_clken", mem_clken, 1);
      @(posedge clk);
      pend_valid = 1'b0;
      if (win >= 0) begin
         prev_winner = win;
         last_addr = q[win].addr;
         if (oor) oor_flag[win] = 1'b1;
         if (q[win].wr && !oor) begin
            w = shadow_rd(q[win].addr);
            for (int b2 = 0; b2 < 4; b2++)
               if (q[win].be[b2]) w[8*b2 +: 8] = q[win].wd[8*b2 +: 8];
            shadow[q[win].addr] = w;
         end
         if (q[win].rd && !q[win].wr) begin
            pend_valid = 1'b1;
            pend_owner = win;
            pend_data = oor ? '0 : shadow_rd(q[win].addr);
         end
      end
   endtask

   // Asserts reset away from a clock edge with both masters requesting, checks the
   // reset values, then releases it and returns just after a rising edge.
   task automatic apply_reset();
      drive(mk(1, 0, 3), mk(1, 0, 4));
      reset_n = 1'b0;
      #1;
      check("rst_m0_waitrequest", m0_waitrequest, 0);
      check("rst_m1_waitrequest", m1_waitrequest, 0);
      check("rst_m0_readdatavalid", m0_readdatavalid, 0);
      check("rst_m1_readdatavalid", m1_readdatavalid, 0);
      check("rst_m0_readdata", m0_readdata, 0);
      check("rst_m1_readdata", m1_readdata, 0);
      check("rst_m0_oor_err", m0_oor_err, 0);
      check("rst_m1_oor_err", m1_oor_err, 0);
      check("rst_mem_chipselect", mem_chipselect, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_writedata", mem_writedata, 0);
      check("rst_mem_byteenable", mem_byteenable, 0);
      check("rst_mem_clken", mem_clken, 0);
      prev_winner = 1; last_addr = 0; pend_valid = 1'b0;
      oor_flag[0] = 1'b0; oor_flag[1] = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_held_readdatavalid", m0_readdatavalid | m1_readdatavalid, 0);
      drive(mk(0, 0, 0), mk(0, 0, 0));
      reset_n = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      apply_reset();

      // Both masters reading continuously: grants alternate starting with m0.
      for (int i = 0; i < 6; i++) run_cycle(mk(1, 0, i), mk(1, 0, 8 + i));

      // m0 write alone is accepted in the same cycle.
      run_cycle(mk(0, 1, 5, 4'hF, 32'h0000_1234), mk(0, 0, 0));

      // m1 partial write then m0 reads the same word on the next cycle.
      run_cycle(mk(0, 0, 0), mk(0, 1, 7, 4'b0011, 32'hCAFE_F00D));
      run_cycle(mk(1, 0, 7), mk(0, 0, 0));
      #2 check("rw_lower16", m0_readdata[15:0], 16'hF00D);

      // Out-of-range read by m0.
      run_cycle(mk(1, 0, NW), mk(0, 0, 0));
      #2;
      check("oor_readdatavalid", m0_readdatavalid, 1);
      check("oor_readdata", m0_readdata, 0);
      check("oor_m0_err", m0_oor_err, 1);
      check("oor_m1_err", m1_oor_err, 0);
      for (int i = 0; i < 3; i++) run_cycle(mk(0, 0, 0), mk(0, 0, 0));

      // m0 alone for ten cycles, then a tie goes to m1.
      for (int i = 0; i < 10; i++) run_cycle(mk(1, 0, i), mk(0, 0, 0));
      run_cycle(mk(1, 0, 1), mk(1, 0, 2));

      for (int i = 0; i < 400; i++) run_cycle(rnd_req(), rnd_req());

      // Reset in the cycle after an accepted read discards its response.
      run_cycle(mk(1, 0, 5), mk(0, 0, 0));
      apply_reset();
      for (int i = 0; i < 3; i++) run_cycle(mk(0, 0, 0), mk(0, 0, 0));
      run_cycle(mk(1, 0, 6), mk(1, 0, 7));
      for (int i = 0; i < 100; i++) run_cycle(rnd_req(), rnd_req());
      run_cycle(mk(0, 0, 0), mk(0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nios_system_onchip_mem_arbiter.md
NIOS_SYSTEM_ONCHIP_MEM_ARBITER -- requirements
Module: nios_system_onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17: word-address width of both masters and the memory port.
REQ-002 Parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 Parameter NUMWORDS, default 100000: words implemented; higher addresses are out of range.
REQ-004 Port clk  in  1: single clock; all logic rising-edge.
REQ-005 Port reset_n  in  1: asynchronous, active-low reset.
REQ-006 Ports m0_address/m1_address  in  ADDR_W: master word address.
REQ-007 Ports m0_byteenable/m1_byteenable  in  DATA_W/8: write byte lanes.
REQ-008 Ports m0_read/m1_read, m0_write/m1_write  in  1 each: request strobes; read and write together is illegal.
REQ-009 Ports m0_writedata/m1_writedata  in  DATA_W: write data.
REQ-010 Ports m0_waitrequest/m1_waitrequest  out  1: request not accepted this cycle.
REQ-011 Ports m0_readdata/m1_readdata  out  DATA_W; m0_readdatavalid/m1_readdatavalid  out  1: read response.
REQ-012 Ports m0_oor_err/m1_oor_err  out  1: sticky out-of-range flag.
REQ-013 Memory ports mem_address (ADDR_W), mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken  out; mem_readdata  in  DATA_W.

Function
REQ-014 Request active = read|write; accepted in the cycle it is granted (waitrequest low).
REQ-015 Grant: one master per cycle; only one requester -> it wins; both -> round-robin against last_grant register (master not granted last time wins).
REQ-016 last_grant updates only on an accepted transfer; idle cycles leave it unchanged.
REQ-017 Non-granted requesting master: waitrequest=1; non-requesting master: waitrequest=0.
REQ-018 Granted master's address/byteenable/writedata driven combinationally to mem_*; mem_chipselect=1; mem_write=granted write.
REQ-019 Idle: mem_chipselect=0, mem_write=0, mem_address/writedata hold previous value.
REQ-020 mem_clken=1 whenever reset_n=1.
REQ-021 Read latency fixed 1 cycle: accepted read in cycle N -> owner's readdatavalid=1 in N+1 with readdata=mem_readdata; pipeline register holds {valid, owner, oor}.
REQ-022 Back-to-back reads (either master) sustain one response per cycle; responses return in issue order.
REQ-023 readdata of non-owner holds last value; readdatavalid=0.
REQ-024 Out of range (address >= NUMWORDS): write accepted, mem_write suppressed (chipselect 0); read accepted, response next cycle with readdata=0, readdatavalid=1; issuing master's oor_err set.
REQ-025 oor_err clears only on reset.
REQ-026 Write and read to same address in consecutive cycles: read returns new data (write completes first).
REQ-027 Illegal read&write: treated as write; read ignored.

Reset
REQ-028 reset_n low asynchronously: waitrequest=0 both, readdatavalid=0 both, readdata=0 both, oor_err=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, last_grant=1 (m0 wins first tie).
REQ-029 Reset mid-read discards the pending response; no readdatavalid after release for pre-reset reads.
REQ-030 Deassertion takes effect on next rising clk edge; no synchronizer inside block.

Structure
REQ-031 Shared package holds ADDR_W/DATA_W/NUMWORDS defaults, master-index type (1 bit) and response-pipeline record type.
REQ-032 One sub-module nios_system_rr_arb2: 2-way round-robin grant from req[1:0] and last_grant; datapath muxing and response pipeline stay in top.
REQ-033 Target 150-300 RTL lines; no memory instance inside block.

Verification
REQ-034 m0 write 0x0000_1234 to addr 5, m1 idle -> same cycle mem_write=1, mem_address=5; m0_waitrequest=0.
REQ-035 Both read continuously after reset -> grants alternate m0,m1,m0,...; each readdatavalid exactly 1 cycle after its acceptance.
REQ-036 m1 writes 0xCAFEF00D byteenable 4'b0011 to addr 7, m0 reads addr 7 next cycle -> m0_readdata lower 16 bits 0xF00D.
REQ-037 m0 reads addr 100000 -> next cycle m0_readdatavalid=1, m0_readdata=0, m0_oor_err=1 sticky; m1_oor_err=0; mem_chipselect=0.
REQ-038 Reset asserted in cycle after accepted read -> no readdatavalid ever appears for it; all outputs at REQ-028 values.
REQ-039 m0 requests alone for 10 cycles -> never stalled; then tie -> m1 wins first.
